// File: rtl/alu_result_stage.sv
// alu_result_stage: registered FIFO capture stage behind the 32-bit add/sub ALU.
// Optional per-entry parity output enabled by defining ALU_RESULT_STAGE_PARITY_EN.
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub_add,
    input  logic [31:0]      in_result,
    input  logic             in_carry,
    input  logic             in_zero,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [4:0]       out_flags,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
`ifdef ALU_RESULT_STAGE_PARITY_EN
    output logic             out_parity,
`endif
    output logic [CNT_W-1:0] op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

    typedef struct packed {
        logic [4:0]  flags;
        logic [31:0] result;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    entry_t          hold_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [OW-1:0]   count_q;
    logic [OW-1:0]   count_next;
    logic            in_ready_q;
    logic            has_entry;
    logic            push;
    logic            pop;
    logic            sticky_q;
    logic [CNT_W-1:0] op_count_q;

    // Handshakes are gated by rst_n so nothing moves on a reset edge.
    assign has_entry = (count_q != '0);
    assign push      = rst_n & in_valid & in_ready_q;
    assign pop       = rst_n & has_entry & out_ready;

    // Negative is derived from the result sign; other flags pass through.
    assign wr_entry.flags  = {in_sub_add, in_result[31], in_overflow,
                              in_zero, in_carry};
    assign wr_entry.result = in_result;

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + OW'(1);
        end else if (pop && !push) begin
            count_next = count_q - OW'(1);
        end
    end

    // Pointers, occupancy, ready, held output, status and counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            hold_q     <= '0;
            sticky_q   <= 1'b0;
            op_count_q <= '0;
        end else begin
            count_q    <= count_next;
            in_ready_q <= (count_next < FULL_CNT);
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + AW'(1);
                op_count_q <= op_count_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                hold_q   <= mem[rd_ptr_q];
            end
            if (push && in_overflow) begin
                sticky_q <= 1'b1;
            end else if (clr_sticky) begin
                sticky_q <= 1'b0;
            end
        end
    end

    // Entry storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // Head entry when occupied, otherwise the last popped entry.
    always_comb begin
        head = hold_q;
        if (has_entry) begin
            head = mem[rd_ptr_q];
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = has_entry;
    assign out_result = head.result;
    assign out_flags  = head.flags;
    assign sticky_ovf = sticky_q;
    assign op_count   = op_count_q;

`ifdef ALU_RESULT_STAGE_PARITY_EN
    logic par_mem [DEPTH];
    logic par_hold_q;

    // Parity is computed once at push time and stored with the entry.
    always_ff @(posedge clk) begin
        if (push) begin
            par_mem[wr_ptr_q] <= ^in_result;
        end
    end

    // Parity of the last popped entry, held while empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_hold_q <= 1'b0;
        end else if (pop) begin
            par_hold_q <= par_mem[rd_ptr_q];
        end
    end

    assign out_parity = has_entry ? par_mem[rd_ptr_q] : par_hold_q;
`endif

endmodule
